// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a parallel word over valid/ready and emits
// preamble + data MSB-first on a single bit, followed by an idle gap.
module seq_pattern_tx #(
    parameter int                                    WIDTH   = 8,
    parameter int                                    PRE_LEN = 3,
    parameter logic [((PRE_LEN > 0) ? PRE_LEN : 1)-1:0] PRE_PAT = 3'b011,
    parameter int                                    GAP_CYC = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             abort_i,
    output logic             sout_o,
    output logic             sout_vld_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int PW  = (PRE_LEN > 0) ? PRE_LEN : 1;
    localparam int SW  = PW + WIDTH;
    localparam int MX1 = (WIDTH > PRE_LEN) ? WIDTH : PRE_LEN;
    localparam int MX2 = (MX1 > GAP_CYC) ? MX1 : GAP_CYC;
    localparam int MX  = (MX2 > 2) ? MX2 : 2;
    localparam int CW  = $clog2(MX);

    localparam logic [CW-1:0] DATA_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_LOAD  = CW'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);
    localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_DATA, S_GAP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   shreg_q, shreg_d;
    logic            sout_q, sout_d;
    logic            vld_q, vld_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [SW-1:0]   frame_word;

    // Preamble and data share one shift register so both phases just shift out the MSB.
    generate
        if (PRE_LEN > 0) begin : g_pre
            assign frame_word = {PRE_PAT, in_data_i};
        end else begin : g_nopre
            assign frame_word = {in_data_i, 1'b0};
        end
    endgenerate

    assign in_ready_o = (state_q == S_IDLE) && !abort_i && rst_ni;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        sout_d  = sout_q;
        vld_d   = vld_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (abort_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            sout_d  = 1'b0;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    sout_d = 1'b0;
                    vld_d  = 1'b0;
                    busy_d = 1'b0;
                    if (in_valid_i && in_ready_o) begin
                        sout_d  = frame_word[SW-1];
                        shreg_d = frame_word << 1;
                        vld_d   = 1'b1;
                        busy_d  = 1'b1;
                        if (PRE_LEN > 0) begin
                            state_d = S_PRE;
                            cnt_d   = PRE_LOAD;
                        end else begin
                            state_d = S_DATA;
                            cnt_d   = DATA_LOAD;
                            done_d  = (WIDTH == 1);
                        end
                    end
                end
                S_PRE: begin
                    sout_d  = shreg_q[SW-1];
                    shreg_d = shreg_q << 1;
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = S_DATA;
                        cnt_d   = DATA_LOAD;
                        done_d  = (WIDTH == 1);
                    end
                end
                S_DATA: begin
                    // cnt_q counts data bits still to come after the one on sout now
                    if (cnt_q != '0) begin
                        sout_d  = shreg_q[SW-1];
                        shreg_d = shreg_q << 1;
                        cnt_d   = cnt_q - 1'b1;
                        done_d  = (cnt_q == CW'(1));
                    end else begin
                        sout_d = 1'b0;
                        vld_d  = 1'b0;
                        if (GAP_CYC > 0) begin
                            state_d = S_GAP;
                            cnt_d   = GAP_LOAD;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                S_GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    sout_d  = 1'b0;
                    vld_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            sout_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            sout_q  <= sout_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign sout_o     = sout_q;
    assign sout_vld_o = vld_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule
